alu_mc: RTL and testbench

- Parametrised multi-cycle successor to the core's 8-bit single-cycle ALU.
- Sits in each compute core's execute stage. Accepts one operation per request while the core is in EXECUTE state.
- ADD/SUB/MUL/logic ops complete in 1 cycle. DIV/REM run on an iterative signed divider (DATA_W cycles).
- Returns result plus NZP flags with a one-cycle response pulse.

---
 rtl/alu_pkg.sv | 23 ++
 rtl/alu_mc_if.sv | 28 ++
 rtl/alu_divider.sv | 55 +++++
 rtl/alu_mc.sv | 165 ++++++++++++++++
 tb/tb_alu_mc.sv | 233 +++++++++++++++++++++++
 5 files changed

// File: rtl/alu_pkg.sv
// Shared opcodes, NZP flag encodings and FSM state type for the multi-cycle ALU.
package alu_pkg;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_MUL = 3'b010;
  localparam logic [2:0] ALU_DIV = 3'b011;
  localparam logic [2:0] ALU_REM = 3'b100;
  localparam logic [2:0] ALU_AND = 3'b101;
  localparam logic [2:0] ALU_OR  = 3'b110;
  localparam logic [2:0] ALU_XOR = 3'b111;

  localparam logic [2:0] NZP_P = 3'b100;
  localparam logic [2:0] NZP_Z = 3'b010;
  localparam logic [2:0] NZP_N = 3'b001;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_DIV_RUN = 2'd1,
    ST_DONE    = 2'd2
  } state_t;

endpackage

// File: rtl/alu_mc_if.sv
// Request/response bundle between the execute stage (master) and alu_mc (slave).
// alu_ovf exists only when ALU_OVF_EN is defined.
interface alu_mc_if #(parameter int DATA_W = 8);
  logic              enable;
  logic [2:0]        core_state;
  logic              req_valid;
  logic              req_ready;
  logic [2:0]        alu_select;
  logic [DATA_W-1:0] operand_1;
  logic [DATA_W-1:0] operand_2;
  logic              resp_valid;
  logic [DATA_W-1:0] alu_out;
  logic [2:0]        alu_nzp;
  logic              div_zero;
`ifdef ALU_OVF_EN
  logic              alu_ovf;

  modport slave (input enable, core_state, req_valid, alu_select, operand_1, operand_2,
                 output req_ready, resp_valid, alu_out, alu_nzp, div_zero, alu_ovf);
  modport master (output enable, core_state, req_valid, alu_select, operand_1, operand_2,
                  input req_ready, resp_valid, alu_out, alu_nzp, div_zero, alu_ovf);
`else
  modport slave (input enable, core_state, req_valid, alu_select, operand_1, operand_2,
                 output req_ready, resp_valid, alu_out, alu_nzp, div_zero);
  modport master (output enable, core_state, req_valid, alu_select, operand_1, operand_2,
                  input req_ready, resp_valid, alu_out, alu_nzp, div_zero);
`endif
endinterface

// File: rtl/alu_divider.sv
// Iterative unsigned restoring divider: one quotient bit per cycle, DATA_W cycles after start.
module alu_divider #(
  parameter int DATA_W = 8
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic [DATA_W-1:0] dividend,
  input  logic [DATA_W-1:0] divisor,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] quotient,
  output logic [DATA_W-1:0] remainder
);
  localparam int CNT_W = $clog2(DATA_W);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(DATA_W - 1);

  logic              busy_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [DATA_W-1:0] quo_q, rem_q, dvs_q;
  logic [DATA_W:0]   trial;
  logic              fits;

  // quo_q doubles as the dividend shift register; its MSB feeds the partial remainder.
  always_comb begin
    trial = {rem_q, quo_q[DATA_W-1]};
    fits  = (trial >= {1'b0, dvs_q});
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      busy_q <= 1'b0;
      cnt_q  <= '0;
      quo_q  <= '0;
      rem_q  <= '0;
      dvs_q  <= '0;
    end else if (start) begin
      busy_q <= 1'b1;
      cnt_q  <= '0;
      quo_q  <= dividend;
      rem_q  <= '0;
      dvs_q  <= divisor;
    end else if (busy_q) begin
      quo_q  <= {quo_q[DATA_W-2:0], fits};
      rem_q  <= fits ? (trial[DATA_W-1:0] - dvs_q) : trial[DATA_W-1:0];
      cnt_q  <= cnt_q + 1'b1;
      if (done) busy_q <= 1'b0;
    end
  end

  assign busy      = busy_q;
  assign done      = busy_q & (cnt_q == LAST);
  assign quotient  = quo_q;
  assign remainder = rem_q;
endmodule

// File: rtl/alu_mc.sv
// Multi-cycle execute-stage ALU: single-cycle ADD/SUB/MUL/logic, iterative signed DIV/REM.
// Defining ALU_OVF_EN adds the alu_ovf output.
module alu_mc
  import alu_pkg::*;
#(
  parameter int         DATA_W     = 8,
  parameter logic [2:0] EXEC_STATE = 3'b101
) (
  input logic     clock,
  input logic     reset,
  alu_mc_if.slave bus
);
  localparam logic [DATA_W-1:0] ZERO = '0;
  localparam logic [DATA_W-1:0] MIN  = {1'b1, {(DATA_W-1){1'b0}}};
  localparam int M = DATA_W - 1;

  state_t            state_q, state_d;
  logic [DATA_W-1:0] out_q, out_d;
  logic [2:0]        nzp_q, nzp_d;
  logic              dz_q, dz_d, rv_q, rv_d;
  logic              is_rem_q, neg_quo_q, neg_rem_q;
  logic              accept, is_div, div_go, div_busy, div_done;
  logic [DATA_W-1:0] op1, op2, sum, diff, prod_lo, imm_res;
  logic [DATA_W-1:0] mag_1, mag_2, quo, rem, quo_s, rem_s, div_res;

  function automatic logic [2:0] nzp_of(input logic [DATA_W-1:0] v);
    logic [2:0] f;
    if (v == ZERO)     f = NZP_Z;
    else if (v[M])     f = NZP_N;
    else               f = NZP_P;
    return f;
  endfunction

  assign op1     = bus.operand_1;
  assign op2     = bus.operand_2;
  assign is_div  = (bus.alu_select == ALU_DIV) || (bus.alu_select == ALU_REM);
  assign accept  = bus.req_valid & bus.req_ready & bus.enable & (bus.core_state == EXEC_STATE);
  assign div_go  = accept & is_div & (op2 != ZERO);
  assign mag_1   = op1[M] ? -op1 : op1;
  assign mag_2   = op2[M] ? -op2 : op2;
  assign sum     = op1 + op2;
  assign diff    = op1 - op2;
  assign prod_lo = op1 * op2;

  always_comb begin
    imm_res = ZERO;
    case (bus.alu_select)
      ALU_ADD: imm_res = sum;
      ALU_SUB: imm_res = diff;
      ALU_MUL: imm_res = prod_lo;
      ALU_AND: imm_res = op1 & op2;
      ALU_OR:  imm_res = op1 | op2;
      ALU_XOR: imm_res = op1 ^ op2;
      default: imm_res = ZERO;  // DIV/REM by zero returns 0
    endcase
  end

  alu_divider #(.DATA_W(DATA_W)) u_div (
    .clock    (clock),
    .reset    (reset),
    .start    (div_go),
    .dividend (mag_1),
    .divisor  (mag_2),
    .busy     (div_busy),
    .done     (div_done),
    .quotient (quo),
    .remainder(rem)
  );

  // MIN/-1 falls out naturally: magnitude quotient MIN with no sign flip.
  assign quo_s   = neg_quo_q ? -quo : quo;
  assign rem_s   = neg_rem_q ? -rem : rem;
  assign div_res = is_rem_q ? rem_s : quo_s;

  always_comb begin
    state_d = state_q;
    out_d   = out_q;
    nzp_d   = nzp_q;
    dz_d    = dz_q;
    rv_d    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (div_go) begin
          state_d = ST_DIV_RUN;
        end else if (accept) begin
          rv_d  = 1'b1;
          out_d = imm_res;
          nzp_d = nzp_of(imm_res);
          dz_d  = is_div;
        end
      end
      ST_DIV_RUN: if (div_done) state_d = ST_DONE;
      ST_DONE: begin
        rv_d    = 1'b1;
        out_d   = div_res;
        nzp_d   = nzp_of(div_res);
        dz_d    = 1'b0;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      out_q     <= '0;
      nzp_q     <= '0;
      dz_q      <= 1'b0;
      rv_q      <= 1'b0;
      is_rem_q  <= 1'b0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
    end else begin
      state_q <= state_d;
      out_q   <= out_d;
      nzp_q   <= nzp_d;
      dz_q    <= dz_d;
      rv_q    <= rv_d;
      if (div_go) begin
        is_rem_q  <= (bus.alu_select == ALU_REM);
        neg_quo_q <= op1[M] ^ op2[M];
        neg_rem_q <= op1[M];
      end
    end
  end

  assign bus.req_ready  = (state_q == ST_IDLE) & ~div_busy;
  assign bus.resp_valid = rv_q;
  assign bus.alu_out    = out_q;
  assign bus.alu_nzp    = nzp_q;
  assign bus.div_zero   = dz_q;

`ifdef ALU_OVF_EN
  logic [2*DATA_W-1:0] prod_full;
  logic                ovf_q, ovf_d, imm_ovf, min_div_q;

  assign prod_full = {{DATA_W{op1[M]}}, op1} * {{DATA_W{op2[M]}}, op2};

  always_comb begin
    imm_ovf = 1'b0;
    case (bus.alu_select)
      ALU_ADD: imm_ovf = (op1[M] == op2[M]) && (sum[M] != op1[M]);
      ALU_SUB: imm_ovf = (op1[M] != op2[M]) && (diff[M] != op1[M]);
      ALU_MUL: imm_ovf = (prod_full[2*DATA_W-1:DATA_W] != {DATA_W{prod_full[M]}});
      default: imm_ovf = 1'b0;
    endcase
    ovf_d = ovf_q;
    if (state_q == ST_IDLE && accept && !div_go) ovf_d = imm_ovf;
    else if (state_q == ST_DONE)                 ovf_d = min_div_q;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      ovf_q     <= 1'b0;
      min_div_q <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
      if (div_go) min_div_q <= (bus.alu_select == ALU_DIV) && (op1 == MIN) && (&op2);
    end
  end

  assign bus.alu_ovf = ovf_q;
`endif
endmodule

// File: tb/tb_alu_mc.sv
// Scoreboard bench for alu_mc (DATA_W=8); checks alu_ovf too when ALU_OVF_EN is defined.
module tb_alu_mc;
  import alu_pkg::*;

  typedef struct {
    logic [7:0] out;
    logic [2:0] nzp;
    logic       dz;
    logic       ovf;
    int         due;
  } exp_t;

  logic clock = 1'b0;
  logic reset;
  int   cyc   = 0;
  int   total = 0;
  int   bad   = 0;
  exp_t sb_q[$];
  exp_t got_e;

  alu_mc_if #(.DATA_W(8)) bus ();

  alu_mc #(.DATA_W(8), .EXEC_STATE(3'b101)) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus.slave)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic exp_t mk(input logic [7:0] out, input logic [2:0] nzp,
                              input logic dz, input logic ovf);
    exp_t e;
    e.out = out; e.nzp = nzp; e.dz = dz; e.ovf = ovf; e.due = 0;
    return e;
  endfunction

  function automatic exp_t model(input logic [2:0] sel, input logic [7:0] a, input logic [7:0] b);
    exp_t e;
    int sa, sb, r;
    sa = int'($signed(a));
    sb = int'($signed(b));
    e.dz = 1'b0; e.ovf = 1'b0; e.due = 0; r = 0;
    case (sel)
      3'd0: r = sa + sb;
      3'd1: r = sa - sb;
      3'd2: r = sa * sb;
      3'd3: if (sb == 0) e.dz = 1'b1; else r = sa / sb;
      3'd4: if (sb == 0) e.dz = 1'b1; else r = sa % sb;
      3'd5: r = int'(a & b);
      3'd6: r = int'(a | b);
      default: r = int'(a ^ b);
    endcase
    if (sel <= 3'd3) e.ovf = (r > 127) || (r < -128);
    e.out = r[7:0];
    e.nzp = (e.out == 8'h00) ? 3'b010 : (e.out[7] ? 3'b001 : 3'b100);
    return e;
  endfunction

  always @(negedge clock) begin
    if (!reset && bus.resp_valid) begin
      if (sb_q.size() == 0) begin
        check("spurious_resp", {31'd0, bus.resp_valid}, 32'd0);
      end else begin
        got_e = sb_q.pop_front();
        check("alu_out", {24'd0, bus.alu_out}, {24'd0, got_e.out});
        check("alu_nzp", {29'd0, bus.alu_nzp}, {29'd0, got_e.nzp});
        check("div_zero", {31'd0, bus.div_zero}, {31'd0, got_e.dz});
        check("latency_cycle", cyc, got_e.due);
`ifdef ALU_OVF_EN
        check("alu_ovf", {31'd0, bus.alu_ovf}, {31'd0, got_e.ovf});
`endif
      end
    end
  end

  // Called just after a posedge; leaves req_valid high so ops can go back-to-back.
  task automatic issue(input logic [2:0] sel, input logic [7:0] a, input logic [7:0] b,
                       input exp_t e, input int lat);
    bus.req_valid  = 1'b1;
    bus.enable     = 1'b1;
    bus.core_state = 3'b101;
    bus.alu_select = sel;
    bus.operand_1  = a;
    bus.operand_2  = b;
    for (int i = 0; i < 40; i++) begin
      @(negedge clock);
      if (bus.req_ready) begin
        e.due = cyc + lat;
        sb_q.push_back(e);
        @(posedge clock); #1;
        return;
      end
      @(posedge clock); #1;
    end
    check("accept_timeout", {31'd0, bus.req_ready}, 32'd1);
  endtask

  task automatic idle_bus();
    bus.req_valid = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 60 && sb_q.size() != 0; i++) @(negedge clock);
    check("drain", sb_q.size(), 0);
    @(posedge clock); #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    @(negedge clock);
    check({tag, "_out"}, {24'd0, bus.alu_out}, 32'd0);
    check({tag, "_nzp"}, {29'd0, bus.alu_nzp}, 32'd0);
    check({tag, "_resp"}, {31'd0, bus.resp_valid}, 32'd0);
    check({tag, "_dz"}, {31'd0, bus.div_zero}, 32'd0);
    check({tag, "_ready"}, {31'd0, bus.req_ready}, 32'd1);
`ifdef ALU_OVF_EN
    check({tag, "_ovf"}, {31'd0, bus.alu_ovf}, 32'd0);
`endif
    @(posedge clock); #1;
  endtask

  logic [7:0] pick [8] = '{8'h00, 8'h01, 8'h7F, 8'h80, 8'hFF, 8'h02, 8'hF9, 8'h55};

  initial begin
    int cnt;
    logic [2:0] sel;
    logic [7:0] a, b;

    reset = 1'b1;
    bus.req_valid = 1'b0; bus.enable = 1'b0; bus.core_state = 3'b000;
    bus.alu_select = 3'b000; bus.operand_1 = 8'h00; bus.operand_2 = 8'h00;
    repeat (2) @(posedge clock);
    #1;
    check_reset_outputs("reset");
    reset = 1'b0;
    @(posedge clock); #1;

    // Single-cycle adds, back-to-back, crossing into signed overflow
    issue(ALU_ADD, 8'd100, 8'd27, mk(8'd127, NZP_P, 1'b0, 1'b0), 1);
    issue(ALU_ADD, 8'd100, 8'd28, mk(8'h80, NZP_N, 1'b0, 1'b1), 1);
    idle_bus();
    drain();

    // Wrong core state, then lane disabled: neither may produce a response
    bus.alu_select = ALU_SUB; bus.operand_1 = 8'd5; bus.operand_2 = 8'd5;
    bus.core_state = 3'b000; bus.enable = 1'b1; bus.req_valid = 1'b1;
    repeat (3) @(posedge clock);
    bus.core_state = 3'b101; bus.enable = 1'b0;
    repeat (3) @(posedge clock);
    #1; idle_bus();
    repeat (4) @(posedge clock);
    #1;
    issue(ALU_SUB, 8'd5, 8'd5, mk(8'h00, NZP_Z, 1'b0, 1'b0), 1);
    idle_bus();
    drain();

    // Signed divide: ready must stay low for DATA_W+1 cycles
    issue(ALU_DIV, 8'hF9, 8'd2, mk(8'hFD, NZP_N, 1'b0, 1'b0), 10);
    idle_bus();
    cnt = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clock);
      if (bus.req_ready) break;
      cnt++;
    end
    check("div_ready_low_cycles", cnt, 9);
    @(posedge clock); #1;
    issue(ALU_REM, 8'hF9, 8'd2, mk(8'hFF, NZP_N, 1'b0, 1'b0), 10);
    idle_bus();
    drain();

    // Divide by zero answers next cycle; a following op clears div_zero
    issue(ALU_DIV, 8'd9, 8'd0, mk(8'h00, NZP_Z, 1'b1, 1'b0), 1);
    issue(ALU_AND, 8'hF0, 8'h3C, mk(8'h30, NZP_P, 1'b0, 1'b0), 1);
    idle_bus();
    drain();

    // MIN / -1 with a stray request pulsed mid-divide
    issue(ALU_DIV, 8'h80, 8'hFF, mk(8'h80, NZP_N, 1'b0, 1'b1), 10);
    idle_bus();
    repeat (3) @(posedge clock);
    #1;
    bus.alu_select = ALU_ADD; bus.operand_1 = 8'd1; bus.operand_2 = 8'd1; bus.req_valid = 1'b1;
    bus.core_state = 3'b000; bus.enable = 1'b0;
    @(posedge clock); #1;
    bus.core_state = 3'b101; bus.enable = 1'b1;
    @(posedge clock); #1;
    idle_bus();
    drain();
    repeat (15) @(posedge clock);
    #1;

    // Reset in the middle of a divide: no response for it
    issue(ALU_DIV, 8'd100, 8'd7, mk(8'd14, NZP_P, 1'b0, 1'b0), 10);
    idle_bus();
    repeat (4) @(posedge clock);
    #1;
    reset = 1'b1;
    sb_q.delete();
    @(posedge clock); #1;
    check_reset_outputs("midreset");
    reset = 1'b0;
    repeat (15) @(posedge clock);
    #1;
    issue(ALU_MUL, 8'd12, 8'd11, mk(8'h84, NZP_N, 1'b0, 1'b1), 1);
    idle_bus();
    drain();

    // Mixed sweep against the reference model
    for (int i = 0; i < 30; i++) begin
      sel = 3'($urandom_range(0, 7));
      a = ($urandom_range(0, 1) == 1) ? pick[$urandom_range(0, 7)] : 8'($urandom);
      b = ($urandom_range(0, 1) == 1) ? pick[$urandom_range(0, 7)] : 8'($urandom);
      issue(sel, a, b, model(sel, a, b),
            ((sel == ALU_DIV || sel == ALU_REM) && b != 8'h00) ? 10 : 1);
    end
    idle_bus();
    drain();
    repeat (5) @(posedge clock);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
